// File: rtl/pc_fetch_seq_if.sv
// pc_fetch_seq_if
// Bundles the fetch sequencer's handshakes into one interface.
//   imem_*  : instruction-memory request/grant/response channel
//   id_*    : valid/ready channel towards decode
//   ex_*    : redirect strobe and target operands from execute
//   pc, pc_misalign : current fetch PC and misaligned-redirect pulse
// Modport master is the sequencer side; modport slave is the environment
// (memory, decode and execute) side.
interface pc_fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        ex_redirect;
  logic [2:0]  ex_npcop;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_aluout;
  logic [31:0] pc;
  logic        pc_misalign;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, pc, pc_misalign,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready,
           ex_redirect, ex_npcop, ex_pc, ex_imm, ex_aluout
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, pc, pc_misalign,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready,
           ex_redirect, ex_npcop, ex_pc, ex_imm, ex_aluout
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq
// Owns the program counter of the multi-cycle core, issues one instruction
// fetch at a time, applies redirects from execute, discards stale responses
// and hands one instruction at a time to decode.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : pc_fetch_seq_if.master (imem, decode and execute handshakes)
// Parameters: RESET_PC (first fetch address), TRAP_VEC (misaligned-target
// redirect, used only when PC_MISALIGN_TRAP_EN is defined).
// Optional feature macro: PC_MISALIGN_TRAP_EN. When undefined, redirect
// targets are forced word-aligned and pc_misalign stays 0.

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'b000
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'b001
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'b010
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'b100
`endif

module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rstn,
  pc_fetch_seq_if.master    bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        misalign_q;

  logic [31:0] raw_tgt_d;
  logic [31:0] tgt_d;
  logic        tgt_misalign_d;

  // Redirect target from the NPCOp code; unknown codes behave like PLUS4.
  always_comb begin
    case (bus.ex_npcop)
      `NPC_BRANCH,
      `NPC_JUMP:   raw_tgt_d = bus.ex_pc + bus.ex_imm;
      `NPC_JALR:   raw_tgt_d = bus.ex_aluout & ~32'h0000_0001;
      default:     raw_tgt_d = bus.ex_pc + 32'd4;
    endcase
  end

  assign tgt_misalign_d = (raw_tgt_d[1:0] != 2'b00);

`ifdef PC_MISALIGN_TRAP_EN
  assign tgt_d = tgt_misalign_d ? TRAP_VEC : raw_tgt_d;
`else
  // Without the trap, a misaligned target simply loses its low bits.
  assign tgt_d = raw_tgt_d & ~32'h0000_0003;
  wire unused_trap_vec = ^{TRAP_VEC, tgt_misalign_d};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      // Pulse only when the redirect is actually applied (not in BOOT).
      if (bus.ex_redirect && state_q != BOOT) misalign_q <= tgt_misalign_d;
`endif
      case (state_q)
        BOOT: state_q <= REQ;

        REQ: begin
          if (bus.ex_redirect) begin
            pc_q <= tgt_d;
            // A grant in the same cycle leaves a response in flight.
            state_q <= bus.imem_gnt ? DRAIN : REQ;
          end else if (bus.imem_gnt) begin
            state_q <= RESP;
          end
        end

        RESP: begin
          if (bus.ex_redirect) begin
            pc_q <= tgt_d;
            // Data arriving with the redirect is dropped; nothing left in flight.
            state_q <= bus.imem_rvalid ? REQ : DRAIN;
          end else if (bus.imem_rvalid) begin
            id_instr_q <= bus.imem_rdata;
            id_pc_q    <= pc_q;
            pc_q       <= pc_q + 32'd4;
            state_q    <= HOLD;
          end
        end

        HOLD: begin
          if (bus.ex_redirect) begin
            pc_q    <= tgt_d;
            state_q <= REQ;
          end else if (bus.id_ready) begin
            state_q <= REQ;
          end
        end

        DRAIN: begin
          if (bus.ex_redirect) pc_q <= tgt_d;
          if (bus.imem_rvalid) state_q <= REQ;
        end

        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = (state_q == HOLD);
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed testbench for pc_fetch_seq with a small responding memory model.

`ifndef NPC_PLUS4
`define NPC_PLUS4  3'b000
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'b001
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'b010
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'b100
`endif

module tb_pc_fetch_seq;
  logic clk;
  logic rstn;

  pc_fetch_seq_if bus();

  pc_fetch_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // memory model state
  bit          auto_gnt;
  int          rdelay;
  bit          pending;
  int          cnt;
  logic [31:0] gaddr;
  logic [31:0] last_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  // Called once per cycle at the falling edge: retire last cycle's strobes,
  // deliver a pending response after rdelay extra cycles, or grant a request.
  task automatic mem_step();
    bus.imem_rvalid = 1'b0;
    if (bus.imem_gnt) begin
      pending = 1'b1;
      cnt     = rdelay;
      gaddr   = last_addr;
    end
    bus.imem_gnt = 1'b0;
    if (pending) begin
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(gaddr);
        pending         = 1'b0;
      end else begin
        cnt--;
      end
    end else if (bus.imem_req && auto_gnt) begin
      bus.imem_gnt = 1'b1;
      last_addr    = bus.imem_addr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.ex_redirect = 1'b0;
    mem_step();
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] p,
                          input logic [31:0] imm, input logic [31:0] alu);
    bus.ex_redirect = 1'b1;
    bus.ex_npcop    = op;
    bus.ex_pc       = p;
    bus.ex_imm      = imm;
    bus.ex_aluout   = alu;
  endtask

  task automatic mem_reset();
    pending         = 1'b0;
    cnt             = 0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    rstn            = 1'b0;
    auto_gnt        = 1'b0;
    rdelay          = 0;
    gaddr           = 32'h0;
    last_addr       = 32'h0;
    bus.imem_rdata  = 32'h0;
    bus.id_ready    = 1'b1;
    bus.ex_redirect = 1'b0;
    bus.ex_npcop    = `NPC_PLUS4;
    bus.ex_pc       = 32'h0;
    bus.ex_imm      = 32'h0;
    bus.ex_aluout   = 32'h0;
    mem_reset();

    #1;
    chk("rst_pc",       bus.pc,                   32'h0);
    chk("rst_req",      {31'h0, bus.imem_req},    32'h0);
    chk("rst_idvalid",  {31'h0, bus.id_valid},    32'h0);
    chk("rst_idinstr",  bus.id_instr,             32'h0);
    chk("rst_idpc",     bus.id_pc,                32'h0);
    chk("rst_misalign", {31'h0, bus.pc_misalign}, 32'h0);

    repeat (2) @(negedge clk);
    rstn     = 1'b1;
    auto_gnt = 1'b1;
    mem_step();
    chk("boot_noreq", {31'h0, bus.imem_req}, 32'h0);

    // --- straight-line fetch with a zero-wait memory ---
    tick();                                   // REQ
    chk("f0_req",  {31'h0, bus.imem_req}, 32'h1);
    chk("f0_addr", bus.imem_addr,         32'h0);
    tick();                                   // RESP
    chk("f0_resp_noreq", {31'h0, bus.imem_req}, 32'h0);
    chk("f0_resp_pc",    bus.pc,                32'h0);
    tick();                                   // HOLD
    chk("f0_valid", {31'h0, bus.id_valid}, 32'h1);
    chk("f0_instr", bus.id_instr,          32'h0000_0013);
    chk("f0_idpc",  bus.id_pc,             32'h0);
    chk("f0_pc",    bus.pc,                32'h4);
    tick();                                   // REQ, 3 cycles after first
    chk("f1_addr", bus.imem_addr,         32'h4);
    chk("f1_req",  {31'h0, bus.imem_req}, 32'h1);
    tick(); tick();                           // RESP, HOLD
    chk("f1_instr", bus.id_instr, 32'h0000_4013);
    tick();                                   // REQ @8
    chk("f2_addr", bus.imem_addr, 32'h8);
    bus.id_ready = 1'b0;
    tick(); tick();                           // RESP, HOLD
    chk("f2_idpc",  bus.id_pc, 32'h8);
    tick();                                   // still HOLD
    chk("hold_stay", {31'h0, bus.id_valid}, 32'h1);
    chk("hold_pc",   bus.pc,                32'hC);

    // --- redirect in HOLD drops the held instruction ---
    redirect(`NPC_BRANCH, 32'h8, 32'hFFFF_FFF8, 32'h0);
    tick();                                   // REQ @0
    chk("hold_redir_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("hold_redir_addr",  bus.imem_addr,         32'h0);
    chk("hold_redir_req",   {31'h0, bus.imem_req}, 32'h1);
    bus.id_ready = 1'b1;
    rdelay       = 3;

    // --- JALR redirect in RESP with a slow response -> DRAIN ---
    tick();                                   // RESP
    redirect(`NPC_JALR, 32'h0, 32'h0, 32'h0000_0205);
    tick();                                   // DRAIN
    chk("jalr_pc",    bus.pc,                32'h204);
    chk("jalr_noreq", {31'h0, bus.imem_req}, 32'h0);
    tick(); tick();                           // stale rvalid arrives
    chk("drain_noreq", {31'h0, bus.imem_req}, 32'h0);
    tick();                                   // REQ
    chk("jalr_addr",   bus.imem_addr,         32'h204);
    chk("jalr_req",    {31'h0, bus.imem_req}, 32'h1);
    chk("stale_instr", bus.id_instr,          32'h0000_8013);
    chk("stale_valid", {31'h0, bus.id_valid}, 32'h0);
    rdelay = 0;

    // --- grant and JUMP redirect in the same REQ cycle ---
    redirect(`NPC_JUMP, 32'h10, 32'h20, 32'h0);
    tick();                                   // DRAIN
    chk("jump_pc",    bus.pc,                32'h30);
    chk("jump_noreq", {31'h0, bus.imem_req}, 32'h0);
    tick();                                   // REQ
    chk("jump_addr", bus.imem_addr, 32'h30);
    tick(); tick();                           // RESP, HOLD
    chk("jump_instr", bus.id_instr, 32'h0003_0013);
    chk("jump_idpc",  bus.id_pc,    32'h30);
    tick();                                   // REQ @0x34
    chk("jump_next", bus.imem_addr, 32'h34);

    // --- misaligned branch target ---
    redirect(`NPC_BRANCH, 32'h0, 32'h6, 32'h0);
    tick();                                   // DRAIN
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc",    bus.pc,                   32'h100);
    chk("mis_pulse", {31'h0, bus.pc_misalign}, 32'h1);
`else
    chk("mis_pc",    bus.pc,                   32'h4);
    chk("mis_pulse", {31'h0, bus.pc_misalign}, 32'h0);
`endif
    tick();                                   // REQ
    chk("mis_pulse_end", {31'h0, bus.pc_misalign}, 32'h0);

    // --- no grant: pc must not move ---
    auto_gnt     = 1'b0;
    bus.imem_gnt = 1'b0;
    tick(); tick();
    chk("stall_req", {31'h0, bus.imem_req}, 32'h1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("stall_pc",  bus.pc, 32'h100);
`else
    chk("stall_pc",  bus.pc, 32'h4);
`endif
    auto_gnt     = 1'b1;
    bus.id_ready = 1'b0;
    tick(); tick(); tick();                   // REQ(gnt), RESP, HOLD
    chk("pre_rst_valid", {31'h0, bus.id_valid}, 32'h1);

    // --- asynchronous reset while in HOLD ---
    #2 rstn = 1'b0;
    auto_gnt = 1'b0;
    mem_reset();
    #1;
    chk("arst_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("arst_pc",    bus.pc,                32'h0);
    chk("arst_req",   {31'h0, bus.imem_req}, 32'h0);
    chk("arst_idpc",  bus.id_pc,             32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_noreq", {31'h0, bus.imem_req}, 32'h0);
    auto_gnt     = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    chk("rel_req",  {31'h0, bus.imem_req}, 32'h1);
    chk("rel_addr", bus.imem_addr,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

Fetch sequencer that owns the program counter of the multi-cycle RISC-V core and issues instruction fetches to instruction memory over a request/grant/response handshake. It computes the next PC with the codebase's NPCOp encodings from ctrl_encode_def.v (`NPC_PLUS4`, `NPC_BRANCH`, `NPC_JUMP`, `NPC_JALR`), applies redirects coming back from execute, discards stale fetch responses, and presents one instruction at a time to decode over a valid/ready handshake.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- TRAP_VEC, 32'h0000_0100, redirect target on a misaligned target; used only with PC_MISALIGN_TRAP_EN.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held until granted.
- imem_addr  out  32  fetch address, always equal to `pc`.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  instruction data valid; at most one per grant, earliest one cycle after grant.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  instruction available to decode.
- id_instr  out  32  captured instruction.
- id_pc  out  32  address of id_instr.
- id_ready  in  1  decode accepts the instruction.
- ex_redirect  in  1  single-cycle redirect strobe from execute.
- ex_npcop  in  3  NPCOp for the redirect.
- ex_pc  in  32  PC of the redirecting instruction.
- ex_imm  in  32  branch/jump offset.
- ex_aluout  in  32  JALR target from the ALU.
- pc  out  32  current fetch PC.
- pc_misalign  out  1  one-cycle pulse on a misaligned redirect target.

## Operation
- States: BOOT, REQ, RESP, HOLD, DRAIN.
- Redirect target, 32-bit with wrap-around:
  - `NPC_BRANCH` and `NPC_JUMP`: ex_pc+ex_imm.
  - `NPC_JALR`: ex_aluout with bit0 cleared.
  - `NPC_PLUS4` and any other code: ex_pc+4.
- BOOT: entered during reset; unconditionally goes to REQ on the next clock.
- REQ: imem_req=1.
  - imem_gnt=1 goes to RESP.
  - ex_redirect=1 loads pc with the target. If imem_gnt=1 in the same cycle, go to DRAIN instead of RESP.
- RESP: waits for the response.
  - imem_rvalid=1 captures id_instr←imem_rdata and id_pc←pc, sets pc←pc+4, goes to HOLD.
  - ex_redirect=1 without imem_rvalid loads pc with the target and goes to DRAIN.
  - ex_redirect=1 with imem_rvalid drops the data, loads pc with the target, goes to REQ.
- HOLD: id_valid=1.
  - id_ready=1 goes to REQ.
  - ex_redirect=1 has priority over id_ready: the held instruction is dropped (id_valid falls next cycle), pc is loaded with the target, go to REQ.
- DRAIN: waits for the stale response.
  - imem_rvalid=1 discards it and goes to REQ.
  - A further ex_redirect reloads pc and stays in DRAIN.
- pc changes only on a redirect or a captured response. It never changes while imem_req=1 and no grant has occurred, except on a redirect.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pc=0, pc_misalign=0, state=BOOT.
- First imem_req: first cycle after rstn rises.
- imem_req and id_valid are decoded from registered state, so they are glitch-free.
- With a zero-wait memory (gnt at cycle n, rvalid at n+1): id_valid at n+2; next REQ at n+3 if id_ready=1 at n+2.
- Redirect latency: target appears on pc/imem_addr the cycle after ex_redirect.
- If rstn is asserted mid-operation, everything returns to reset values immediately. Any in-flight response is the memory's responsibility to squash.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect target with bits[1:0]≠0 loads pc with TRAP_VEC instead of the target.
  - pc_misalign pulses high for exactly one cycle, the cycle after ex_redirect.
- Undefined:
  - Target bits[1:0] are forced to 0.
  - pc_misalign is tied to 0; TRAP_VEC is unused.

## Test plan
- Reset release, gnt and rvalid immediate, rdata=32'h00000013, id_ready=1 → first imem_addr=0, id_instr=32'h13 with id_pc=0, next imem_addr=4, one instruction every 3 cycles.
- In HOLD with id_ready=0 and id_pc=8, pulse redirect with `NPC_BRANCH`, ex_pc=8, ex_imm=32'hFFFF_FFF8 → id_valid falls, next imem_addr=0, instruction at 8 never consumed.
- Redirect with `NPC_JALR`, ex_aluout=32'h0000_0205, in RESP with rvalid delayed 3 cycles → DRAIN; stale rdata discarded; next imem_addr=32'h204.
- In REQ, gnt and redirect (`NPC_JUMP`, ex_pc=32'h10, ex_imm=32'h20) in the same cycle → DRAIN; after rvalid, imem_addr=32'h30.
- With macro defined, `NPC_BRANCH` redirect with ex_pc=0, ex_imm=6 → pc=TRAP_VEC and one-cycle pc_misalign. Without macro → pc=4, pc_misalign=0.
- Assert rstn low while in HOLD → id_valid=0, pc=RESET_PC immediately (asynchronous), imem_req=0 until the cycle after release.
